nibble_serial_sub: RTL
======================

// Module: nibble_serial_sub
// PURPOSE
//  Multi-cycle WIDTH-bit subtractor, d = a - b, computed one nibble per clock.
//  Uses one cla4 instance as a 4-bit slice: a + ~b + carry, with a registered carry between nibbles.
//  Serves as the subtract-side counterpart to the combinational cla4 adder path.
//  Trades latency for area in datapaths that need wide subtraction at low gate count.
//  Uses a start/done handshake.
// PARAMETERS
//  WIDTH   16   operand/result width in bits; must be a multiple of 4 and >= 8
// PORTS
//  clk      in   1      rising-edge clock
//  reset_n  in   1      asynchronous reset, active-low
//  start    in   1      request; samples a/b when the block is ready (state IDLE or DONE)
//  abort    in   1      synchronous cancel of a running operation
//  a        in   WIDTH  minuend, sampled only on an accepted start
//  b        in   WIDTH  subtrahend, sampled only on an accepted start
//  busy     out  1      high while in RUN
//  done     out  1      one-cycle pulse: result outputs are valid
//  d        out  WIDTH  difference a - b, modulo 2^WIDTH
//  bo       out  1      unsigned borrow: 1 iff a < b (unsigned)
//  ovf      out  1      signed overflow of two's-complement a - b
//  zero     out  1      1 iff d == 0
// BEHAVIOUR
//  States:
//   - IDLE: waiting for a request.
//   - RUN: processing nibbles; a nibble counter runs from 0 to N-1, where N = WIDTH/4.
//   - DONE: result presented for one cycle.
//  Reset (reset_n=0, async):
//   - State goes to IDLE.
//   - busy, done, d, bo, ovf and zero are all 0.
//   - Counter, carry and operand shift registers are cleared.
//  IDLE/DONE + start=1:
//   - Latch a into A_sh and ~b into B_sh.
//   - Set carry=1, counter=0, and go to RUN.
//   - Latch a[MSB] and b[MSB] for the overflow calculation.
//  RUN, each cycle:
//   - Compute {c4, s4} = cla4(A_sh[3:0], B_sh[3:0], carry).
//   - Shift s4 into the result register from the top.
//   - Shift A_sh and B_sh right by 4 bits and set carry = c4.
//   - If counter == N-1, go to DONE; otherwise increment the counter.
//  DONE (exactly one cycle, done=1):
//   - d holds the full result.
//   - bo = ~final_carry.
//   - ovf = (a_msb != b_msb) && (d[MSB] != a_msb).
//   - zero = (d == 0).
//   - Next state is RUN if start=1, otherwise IDLE.
//  Latency: an accepted start at edge k gives done=1 in the cycle after edge k+N (N=4 for WIDTH=16).
//   Back-to-back operations yield one result every N+1 cycles.
//  d, bo, ovf and zero are held stable from DONE until the next DONE; they are not cleared in IDLE.
//   The result register is internal and d updates only on entry to DONE, so d never shows partial nibbles.
//  start while in RUN is ignored; no queueing.
//  abort=1 in RUN:
//   - Go to IDLE next cycle with no done pulse.
//   - d, bo, ovf and zero keep their previous values.
//   - abort has priority over a counter wrap in the same cycle.
//   - abort outside RUN has no effect.
//  start and abort both 1 in DONE: start wins; abort applies only in RUN.
//  reset_n deasserted mid-RUN: the operation is lost, all outputs return to 0, and no done pulse is produced.
//  Arithmetic is pure modulo 2^WIDTH; no saturation.
// TESTING
//  1. a=0x1234, b=0x0235, start 1 cycle -> done 5 cycles later; d=0x0FFF, bo=0, ovf=0, zero=0.
//  2. a=0x0000, b=0x0001 -> d=0xFFFF, bo=1, ovf=0.
//     a=0x8000, b=0x0001 -> d=0x7FFF, bo=0, ovf=1.
//  3. a=0x5A5A, b=0x5A5A -> d=0x0000, zero=1, bo=0.
//     Then start held high in DONE with a=3, b=5 -> next done 5 cycles later with d=0xFFFE, bo=1.
//  4. Start a=0x0010, b=0x0001; pulse start with a=0xFFFF, b=0 during RUN
//     -> only one done, with d=0x000F; busy stays high for 4 cycles.
//  5. Abort at counter=2 -> no done, busy falls next cycle, prior d retained.
//     Then reset_n=0 mid-RUN -> all outputs 0 immediately (async), state IDLE.
//  6. Random a/b (>=1000 vectors, WIDTH=16 and WIDTH=8) -> d, bo, ovf and zero match a reference model.

Source files
------------

// File: rtl/nibble_serial_sub.sv
// rtl/nibble_serial_sub.sv - nibble-serial WIDTH-bit subtractor built around a single 4-bit CLA slice

module cla4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ c[3:0];
        co   = c[4];
    end
endmodule

module nibble_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf,
    output logic             zero
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic [3:0]       s4;
    logic             c4;
    logic [WIDTH-1:0] res_next;
    logic             last;

    cla4 u_slice (
        .x  (a_sh[3:0]),
        .y  (b_sh[3:0]),
        .ci (carry),
        .s  (s4),
        .co (c4)
    );

    // Result fills from the top so the final nibble lands at the MSB end.
    assign res_next = {s4, res_sh[WIDTH-1:4]};
    assign last     = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            bo     <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= ~b;
                        carry <= 1'b1;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        res_sh <= res_next;
                        a_sh   <= a_sh >> 4;
                        b_sh   <= b_sh >> 4;
                        carry  <= c4;
                        if (last) begin
                            // Publish all result flags together on entry to DONE.
                            d     <= res_next;
                            bo    <= ~c4;
                            ovf   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
                            zero  <= (res_next == '0);
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
